// File: rtl/ad9914_pkg.sv
// Shared constants for the AD9914 parallel-port responder: register byte offsets and port widths.
package ad9914_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  localparam logic [ADDR_W-1:0] CFR1      = 8'h00;
  localparam logic [ADDR_W-1:0] DRG_LL    = 8'h10;
  localparam logic [ADDR_W-1:0] DRG_UL    = 8'h14;
  localparam logic [ADDR_W-1:0] DRG_RS    = 8'h18;
  localparam logic [ADDR_W-1:0] DRG_FS    = 8'h1C;
  localparam logic [ADDR_W-1:0] DRG_RATE  = 8'h20;
  localparam logic [ADDR_W-1:0] PROF0_FTW = 8'h2C;

  // Little-endian assembly of four consecutive register bytes.
  function automatic logic [31:0] le_word(input logic [DATA_W-1:0] b0,
                                          input logic [DATA_W-1:0] b1,
                                          input logic [DATA_W-1:0] b2,
                                          input logic [DATA_W-1:0] b3);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/ad9914_strobe_sync.sv
// Multi-flop synchroniser for one asynchronous strobe, followed by an edge-detect flop.
module ad9914_strobe_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift chain and edge-history flop, both parked at the strobe's idle level in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= {SYNC_STAGES{IDLE}};
      r_prev <= IDLE;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/ad9914_par_responder.sv
// Device-side AD9914 parallel port: buffered/active register banks, io_update promotion,
// registered read-back and decoded DRG words.
module ad9914_par_responder
  import ad9914_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_pwd,
  input  logic              p_wr,
  input  logic              p_rd,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data_in,
  output logic [DATA_W-1:0] p_data_out,
  output logic              p_data_oe,
  input  logic              io_update,
  input  logic              master_reset,
  output logic [31:0]       lower_limit,
  output logic [31:0]       upper_limit,
  output logic [31:0]       rate,
  output logic              update_pulse,
  output logic [15:0]       wr_count,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_buf [DEPTH];
  logic [DATA_W-1:0] r_act [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic [31:0]       r_ll;
  logic [31:0]       r_ul;
  logic [31:0]       r_rate;
  logic              r_upd;
  logic [15:0]       r_cnt;
  logic              r_err;

  logic w_wr_lvl, w_wr_rise, w_unused_wr_fall, w_unused_wr_lvl;
  logic w_rd_lvl, w_unused_rd_rise, w_unused_rd_fall;
  logic w_io_rise, w_unused_io_fall, w_unused_io_lvl;
  logic w_mr_lvl, w_unused_mr_rise, w_unused_mr_fall;

  ad9914_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_wr (
    .clk(clk), .rst(rst), .i_async(p_wr),
    .o_level(w_unused_wr_lvl), .o_rise(w_wr_rise), .o_fall(w_unused_wr_fall)
  );
  ad9914_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_rd (
    .clk(clk), .rst(rst), .i_async(p_rd),
    .o_level(w_rd_lvl), .o_rise(w_unused_rd_rise), .o_fall(w_unused_rd_fall)
  );
  ad9914_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_io (
    .clk(clk), .rst(rst), .i_async(io_update),
    .o_level(w_unused_io_lvl), .o_rise(w_io_rise), .o_fall(w_unused_io_fall)
  );
  ad9914_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_mr (
    .clk(clk), .rst(rst), .i_async(master_reset),
    .o_level(w_mr_lvl), .o_rise(w_unused_mr_rise), .o_fall(w_unused_mr_fall)
  );

  assign w_wr_lvl = w_unused_wr_lvl;

  logic             w_addr_ok;
  logic [IDX_W-1:0] w_idx;
  logic             w_wr_ok;
  logic             w_wr_bad;
  logic             w_rd_act;
  logic             w_rd_bad;

  assign w_addr_ok = ({{(32-ADDR_W){1'b0}}, p_addr} < 32'(DEPTH));
  assign w_idx     = p_addr[IDX_W-1:0];
  assign w_wr_ok   = w_wr_rise & ~p_pwd & w_addr_ok & ~w_mr_lvl;
  assign w_wr_bad  = w_wr_rise & ~p_pwd & ~w_addr_ok;
  assign w_rd_act  = ~w_rd_lvl & ~p_pwd;
  assign w_rd_bad  = w_rd_act & ~w_addr_ok;

  // Words that would run past the end of the bank read as zero.
  function automatic logic [31:0] word_at(input int base);
    if (base + 3 < DEPTH) begin
      return le_word(r_act[base], r_act[base+1], r_act[base+2], r_act[base+3]);
    end else begin
      return 32'h0000_0000;
    end
  endfunction

  // Banks: master_reset dominates; a same-cycle promote copies buf before the write lands.
  always_ff @(posedge clk) begin
    if (!rst || w_mr_lvl) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= {DATA_W{1'b0}};
        r_act[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (w_io_rise) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_act[i] <= r_buf[i];
        end
      end
      if (w_wr_ok) begin
        r_buf[w_idx] <= p_data_in;
      end
    end
  end

  // Status, read-back and exported words, all registered from the active bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_upd  <= 1'b0;
      r_cnt  <= 16'h0000;
      r_err  <= 1'b0;
      r_dout <= {DATA_W{1'b0}};
      r_ll   <= 32'h0000_0000;
      r_ul   <= 32'h0000_0000;
      r_rate <= 32'h0000_0000;
    end else begin
      r_upd <= w_io_rise & ~w_mr_lvl;
      if (w_wr_ok && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_wr_bad || w_rd_bad) begin
        r_err <= 1'b1;
      end
      if (w_rd_act) begin
        r_dout <= w_addr_ok ? r_act[w_idx] : {DATA_W{1'b0}};
      end
      r_ll   <= word_at(int'(DRG_LL));
      r_ul   <= word_at(int'(DRG_UL));
      r_rate <= word_at(int'(DRG_RATE));
    end
  end

  assign p_data_out   = r_dout;
  assign p_data_oe    = w_rd_act;
  assign lower_limit  = r_ll;
  assign upper_limit  = r_ul;
  assign rate         = r_rate;
  assign update_pulse = r_upd;
  assign wr_count     = r_cnt;
  assign addr_err     = r_err;

endmodule
